// File: rtl/framebuffer_dbuf.sv
// ---------------------------------------------------------------------------
// framebuffer_dbuf
//   Double-buffered on-chip framebuffer. The renderer always writes the back
//   bank, display scan-out always reads the front bank, and a front/back swap
//   is only committed on a frame-end strobe so the displayed image never
//   tears. A clear engine fills the back bank with a solid colour, one pixel
//   per cycle.
//
// Ports
//   iClk, iRst_n              clock, synchronous active-low reset
//   iWE/iWAddr/iWData         pixel write into the back bank
//   iRE/iRAddr                pixel read request from the front bank
//   oRData/oRValid            read data, one cycle after iRE
//   iSwapReq/iFrameEnd        swap request pulse / end-of-frame pulse
//   oSwapPending/oFrontSel    swap waiting for frame end / displayed bank
//   iClearReq/iClearColor     start a clear of the back bank with a colour
//   oClearBusy/oClearDone     clear running / one-cycle completion pulse
// ---------------------------------------------------------------------------
module framebuffer_dbuf #(
    parameter int H_RES  = 320,
    parameter int V_RES  = 240,
    parameter int PIX_W  = 12,
    parameter int ADDR_W = 17
) (
    input  logic              iClk,
    input  logic              iRst_n,
    input  logic              iWE,
    input  logic [ADDR_W-1:0] iWAddr,
    input  logic [PIX_W-1:0]  iWData,
    input  logic              iRE,
    input  logic [ADDR_W-1:0] iRAddr,
    output logic [PIX_W-1:0]  oRData,
    output logic              oRValid,
    input  logic              iSwapReq,
    input  logic              iFrameEnd,
    output logic              oSwapPending,
    output logic              oFrontSel,
    input  logic              iClearReq,
    input  logic [PIX_W-1:0]  iClearColor,
    output logic              oClearBusy,
    output logic              oClearDone
);

    localparam int NPIX = H_RES * V_RES;

    // One bit wider than the address so the range check still works when
    // NPIX is exactly 2^ADDR_W.
    localparam logic [ADDR_W:0]   LP_NPIX = (ADDR_W + 1)'(NPIX);
    localparam logic [ADDR_W-1:0] LP_LAST = ADDR_W'(NPIX - 1);

    typedef enum logic {
        ST_IDLE,
        ST_FILL
    } clr_state_t;

    // -----------------------------------------------------------------------
    // Storage (not reset)
    // -----------------------------------------------------------------------
    logic [PIX_W-1:0] r_bank0 [NPIX];
    logic [PIX_W-1:0] r_bank1 [NPIX];

    // -----------------------------------------------------------------------
    // Registers and wires
    // -----------------------------------------------------------------------
    clr_state_t        r_state;
    clr_state_t        w_state_nxt;
    logic [ADDR_W-1:0] r_clr_cnt;
    logic [PIX_W-1:0]  r_clr_color;
    logic              r_clr_done;

    logic              r_front;
    logic              r_pending;

    logic [PIX_W-1:0]  r_rdata;
    logic              r_rvalid;

    logic              w_busy;
    logic              w_clr_we;
    logic              w_clr_last;
    logic              w_clr_start;

    logic              w_user_we;
    logic              w_wr_en;
    logic [ADDR_W-1:0] w_wr_addr;
    logic [PIX_W-1:0]  w_wr_data;
    logic              w_rd_in_range;
    logic              w_commit;

    // -----------------------------------------------------------------------
    // Clear FSM: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge iClk) begin
        if (!iRst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Clear FSM: next state
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (iClearReq)  w_state_nxt = ST_FILL;
            ST_FILL: if (w_clr_last) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Clear FSM: outputs
    always_comb begin
        w_busy   = 1'b0;
        w_clr_we = 1'b0;
        case (r_state)
            ST_FILL: begin
                w_busy   = 1'b1;
                w_clr_we = 1'b1;
            end
            default: begin
                w_busy   = 1'b0;
                w_clr_we = 1'b0;
            end
        endcase
    end

    assign w_clr_last  = (r_state == ST_FILL) && (r_clr_cnt == LP_LAST);
    assign w_clr_start = (r_state == ST_IDLE) && iClearReq;

    // Clear datapath: fill pointer, latched colour, completion pulse
    always_ff @(posedge iClk) begin
        if (!iRst_n) begin
            r_clr_cnt   <= '0;
            r_clr_color <= '0;
            r_clr_done  <= 1'b0;
        end else begin
            r_clr_done <= w_clr_last;
            if (w_clr_start) begin
                r_clr_cnt   <= '0;
                r_clr_color <= iClearColor;
            end else if (w_clr_last) begin
                r_clr_cnt   <= '0;
            end else if (w_clr_we) begin
                r_clr_cnt   <= r_clr_cnt + 1'b1;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Write port: back bank = ~r_front. The clear engine owns the port while
    // busy; user writes are dropped then, and out-of-range ones always.
    // -----------------------------------------------------------------------
    assign w_user_we = iWE && !w_busy && ({1'b0, iWAddr} < LP_NPIX);
    assign w_wr_en   = w_user_we || w_clr_we;
    assign w_wr_addr = w_clr_we ? r_clr_cnt   : iWAddr;
    assign w_wr_data = w_clr_we ? r_clr_color : iWData;

    always_ff @(posedge iClk) begin
        if (w_wr_en && r_front) begin
            r_bank0[w_wr_addr] <= w_wr_data;
        end
    end

    always_ff @(posedge iClk) begin
        if (w_wr_en && !r_front) begin
            r_bank1[w_wr_addr] <= w_wr_data;
        end
    end

    // -----------------------------------------------------------------------
    // Read port: front bank, 1-cycle latency, data held when idle
    // -----------------------------------------------------------------------
    assign w_rd_in_range = ({1'b0, iRAddr} < LP_NPIX);

    always_ff @(posedge iClk) begin
        if (!iRst_n) begin
            r_rdata  <= '0;
            r_rvalid <= 1'b0;
        end else begin
            r_rvalid <= iRE;
            if (iRE) begin
                if (!w_rd_in_range) begin
                    r_rdata <= '0;
                end else if (r_front) begin
                    r_rdata <= r_bank1[iRAddr];
                end else begin
                    r_rdata <= r_bank0[iRAddr];
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Swap control. A request arriving together with iFrameEnd commits at
    // once; commits are held off while the clear engine owns the back bank.
    // -----------------------------------------------------------------------
    assign w_commit = iFrameEnd && !w_busy && (r_pending || iSwapReq);

    always_ff @(posedge iClk) begin
        if (!iRst_n) begin
            r_front   <= 1'b0;
            r_pending <= 1'b0;
        end else if (w_commit) begin
            r_front   <= ~r_front;
            r_pending <= 1'b0;
        end else if (iSwapReq) begin
            r_pending <= 1'b1;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign oRData       = r_rdata;
    assign oRValid      = r_rvalid;
    assign oSwapPending = r_pending;
    assign oFrontSel    = r_front;
    assign oClearBusy   = w_busy;
    assign oClearDone   = r_clr_done;

endmodule

// File: tb/tb_framebuffer_dbuf.sv
// ---------------------------------------------------------------------------
// tb_framebuffer_dbuf
//   Directed self-checking bench for framebuffer_dbuf, built with a reduced
//   20x12 frame (NPIX = 240) so full clears stay short.
// ---------------------------------------------------------------------------
module tb_framebuffer_dbuf;

    localparam int H_RES  = 20;
    localparam int V_RES  = 12;
    localparam int PIX_W  = 12;
    localparam int ADDR_W = 8;
    localparam int NPIX   = H_RES * V_RES;

    logic              iClk = 1'b0;
    logic              iRst_n;
    logic              iWE;
    logic [ADDR_W-1:0] iWAddr;
    logic [PIX_W-1:0]  iWData;
    logic              iRE;
    logic [ADDR_W-1:0] iRAddr;
    logic [PIX_W-1:0]  oRData;
    logic              oRValid;
    logic              iSwapReq;
    logic              iFrameEnd;
    logic              oSwapPending;
    logic              oFrontSel;
    logic              iClearReq;
    logic [PIX_W-1:0]  iClearColor;
    logic              oClearBusy;
    logic              oClearDone;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 iClk = ~iClk;

    framebuffer_dbuf #(
        .H_RES (H_RES),
        .V_RES (V_RES),
        .PIX_W (PIX_W),
        .ADDR_W(ADDR_W)
    ) dut (
        .iClk        (iClk),
        .iRst_n      (iRst_n),
        .iWE         (iWE),
        .iWAddr      (iWAddr),
        .iWData      (iWData),
        .iRE         (iRE),
        .iRAddr      (iRAddr),
        .oRData      (oRData),
        .oRValid     (oRValid),
        .iSwapReq    (iSwapReq),
        .iFrameEnd   (iFrameEnd),
        .oSwapPending(oSwapPending),
        .oFrontSel   (oFrontSel),
        .iClearReq   (iClearReq),
        .iClearColor (iClearColor),
        .oClearBusy  (oClearBusy),
        .oClearDone  (oClearDone)
    );

    // Advance one edge; outputs are sampled and inputs changed 1ns later.
    task automatic tick();
        @(posedge iClk);
        #1;
    endtask

    task automatic do_write(input logic [ADDR_W-1:0] a, input logic [PIX_W-1:0] d);
        iWE = 1'b1; iWAddr = a; iWData = d;
        tick();
        iWE = 1'b0;
    endtask

    task automatic do_read(input logic [ADDR_W-1:0] a, output logic [PIX_W-1:0] d,
                           output logic v);
        iRE = 1'b1; iRAddr = a;
        tick();
        d = oRData; v = oRValid;
        iRE = 1'b0;
    endtask

    task automatic do_swap();
        iSwapReq = 1'b1;
        tick();
        iSwapReq = 1'b0; iFrameEnd = 1'b1;
        tick();
        iFrameEnd = 1'b0;
    endtask

    // -----------------------------------------------------------------------
    task automatic test_reset();
        iRst_n = 1'b0;
        tick();
        tick();
        n_cmp++; if (oRData !== 12'h000) begin n_bad++; $display("FAIL reset_rdata: got %h expected %h", oRData, 12'h000); end
        n_cmp++; if (oRValid !== 1'b0) begin n_bad++; $display("FAIL reset_rvalid: got %b expected 0", oRValid); end
        n_cmp++; if (oFrontSel !== 1'b0) begin n_bad++; $display("FAIL reset_front: got %b expected 0", oFrontSel); end
        n_cmp++; if (oSwapPending !== 1'b0) begin n_bad++; $display("FAIL reset_pending: got %b expected 0", oSwapPending); end
        n_cmp++; if (oClearBusy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b expected 0", oClearBusy); end
        n_cmp++; if (oClearDone !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b expected 0", oClearDone); end
        iRst_n = 1'b1;
        tick();
    endtask

    // Front 0 -> write back bank 1 -> swap -> read it back.
    task automatic test_basic();
        do_write(8'd5, 12'hABC);
        do_swap();
        n_cmp++; if (oFrontSel !== 1'b1) begin n_bad++; $display("FAIL basic_front: got %b expected 1", oFrontSel); end
        n_cmp++; if (oSwapPending !== 1'b0) begin n_bad++; $display("FAIL basic_pending: got %b expected 0", oSwapPending); end
        iRE = 1'b1; iRAddr = 8'd5;
        tick();
        iRE = 1'b0;
        n_cmp++; if (oRData !== 12'hABC) begin n_bad++; $display("FAIL basic_rdata: got %h expected %h", oRData, 12'hABC); end
        n_cmp++; if (oRValid !== 1'b1) begin n_bad++; $display("FAIL basic_rvalid: got %b expected 1", oRValid); end
        tick();
        n_cmp++; if (oRValid !== 1'b0) begin n_bad++; $display("FAIL basic_rvalid_drop: got %b expected 0", oRValid); end
        n_cmp++; if (oRData !== 12'hABC) begin n_bad++; $display("FAIL basic_rdata_hold: got %h expected %h", oRData, 12'hABC); end
    endtask

    // Front 1 -> populate bank 0 edges, out-of-range writes, swap, read.
    task automatic test_range();
        logic [PIX_W-1:0] d;
        logic v;
        do_write(8'd0, 12'h111);
        do_write(ADDR_W'(NPIX - 1), 12'h222);
        do_write(ADDR_W'(NPIX), 12'hFFF);
        do_write(8'hFF, 12'hEEE);
        do_swap();
        n_cmp++; if (oFrontSel !== 1'b0) begin n_bad++; $display("FAIL range_front: got %b expected 0", oFrontSel); end
        do_read(8'd0, d, v);
        n_cmp++; if (d !== 12'h111) begin n_bad++; $display("FAIL range_addr0: got %h expected %h", d, 12'h111); end
        do_read(ADDR_W'(NPIX), d, v);
        n_cmp++; if (d !== 12'h000) begin n_bad++; $display("FAIL range_rd_npix: got %h expected %h", d, 12'h000); end
        n_cmp++; if (v !== 1'b1) begin n_bad++; $display("FAIL range_rd_npix_valid: got %b expected 1", v); end
        do_read(ADDR_W'(NPIX - 1), d, v);
        n_cmp++; if (d !== 12'h222) begin n_bad++; $display("FAIL range_addr_last: got %h expected %h", d, 12'h222); end
        do_read(8'hFF, d, v);
        n_cmp++; if (d !== 12'h000) begin n_bad++; $display("FAIL range_rd_ff: got %h expected %h", d, 12'h000); end
    endtask

    // Front 0. Request at cycle 10 (repeat at 20), frame ends at 50 and 53.
    task automatic test_swap_timing();
        logic exp_pend;
        logic exp_front;
        for (int c = 0; c <= 55; c++) begin
            iSwapReq  = (c == 10) || (c == 20);
            iFrameEnd = (c == 50) || (c == 53);
            tick();
            exp_pend  = (c >= 10) && (c < 50);
            exp_front = (c >= 50);
            n_cmp++; if (oSwapPending !== exp_pend) begin n_bad++; $display("FAIL swap_pending c=%0d: got %b expected %b", c, oSwapPending, exp_pend); end
            n_cmp++; if (oFrontSel !== exp_front) begin n_bad++; $display("FAIL swap_front c=%0d: got %b expected %b", c, oFrontSel, exp_front); end
        end
        iSwapReq = 1'b1; iFrameEnd = 1'b1;
        tick();
        iSwapReq = 1'b0; iFrameEnd = 1'b0;
        n_cmp++; if (oFrontSel !== 1'b0) begin n_bad++; $display("FAIL swap_same_front: got %b expected 0", oFrontSel); end
        n_cmp++; if (oSwapPending !== 1'b0) begin n_bad++; $display("FAIL swap_same_pending: got %b expected 0", oSwapPending); end
        tick();
        n_cmp++; if (oSwapPending !== 1'b0) begin n_bad++; $display("FAIL swap_same_pending_after: got %b expected 0", oSwapPending); end
    endtask

    // Front 0: clear bank 1 with 0x0F0, then show it.
    task automatic test_clear();
        int busy_cnt = 0;
        int done_cnt = 0;
        int done_idx = -1;
        logic [PIX_W-1:0] d;
        logic v;
        iClearReq = 1'b1; iClearColor = 12'h0F0;
        iWE = 1'b1; iWAddr = 8'd3; iWData = 12'h777;
        tick();
        iClearReq = 1'b0; iClearColor = 12'hFFF; iWE = 1'b0;
        for (int k = 0; k < NPIX + 8; k++) begin
            if (oClearBusy) busy_cnt++;
            if (oClearDone) begin done_cnt++; done_idx = k; end
            iWE = (k == NPIX - 5); iWAddr = 8'd0; iWData = 12'h777;
            iClearReq = (k == 50); iClearColor = 12'h00F;
            tick();
        end
        iWE = 1'b0; iClearReq = 1'b0;
        n_cmp++; if (busy_cnt !== NPIX) begin n_bad++; $display("FAIL clear_busy_cycles: got %0d expected %0d", busy_cnt, NPIX); end
        n_cmp++; if (done_cnt !== 1) begin n_bad++; $display("FAIL clear_done_pulses: got %0d expected 1", done_cnt); end
        n_cmp++; if (done_idx !== NPIX) begin n_bad++; $display("FAIL clear_done_cycle: got %0d expected %0d", done_idx, NPIX); end
        do_swap();
        n_cmp++; if (oFrontSel !== 1'b1) begin n_bad++; $display("FAIL clear_front: got %b expected 1", oFrontSel); end
        do_read(8'd0, d, v);
        n_cmp++; if (d !== 12'h0F0) begin n_bad++; $display("FAIL clear_addr0: got %h expected %h", d, 12'h0F0); end
        do_read(8'd3, d, v);
        n_cmp++; if (d !== 12'h0F0) begin n_bad++; $display("FAIL clear_addr3: got %h expected %h", d, 12'h0F0); end
        do_read(ADDR_W'(NPIX / 2), d, v);
        n_cmp++; if (d !== 12'h0F0) begin n_bad++; $display("FAIL clear_addr_mid: got %h expected %h", d, 12'h0F0); end
        do_read(ADDR_W'(NPIX - 1), d, v);
        n_cmp++; if (d !== 12'h0F0) begin n_bad++; $display("FAIL clear_addr_last: got %h expected %h", d, 12'h0F0); end
    endtask

    // Front 1: clear bank 0 with 0xA5A while frame ends arrive.
    task automatic test_swap_during_clear();
        logic [PIX_W-1:0] d;
        logic v;
        iClearReq = 1'b1; iClearColor = 12'hA5A;
        tick();
        iClearReq = 1'b0;
        for (int k = 0; k < NPIX + 4; k++) begin
            iSwapReq  = (k == 20);
            iFrameEnd = (k == 20) || (k == 60) || (k == NPIX - 1);
            tick();
            if (k == 20 || k == 60 || k == NPIX - 1) begin
                n_cmp++; if (oFrontSel !== 1'b1) begin n_bad++; $display("FAIL blk_front k=%0d: got %b expected 1", k, oFrontSel); end
                n_cmp++; if (oSwapPending !== 1'b1) begin n_bad++; $display("FAIL blk_pending k=%0d: got %b expected 1", k, oSwapPending); end
            end
        end
        iSwapReq = 1'b0; iFrameEnd = 1'b0;
        n_cmp++; if (oSwapPending !== 1'b1) begin n_bad++; $display("FAIL blk_pending_after: got %b expected 1", oSwapPending); end
        iFrameEnd = 1'b1;
        tick();
        iFrameEnd = 1'b0;
        n_cmp++; if (oFrontSel !== 1'b0) begin n_bad++; $display("FAIL blk_commit_front: got %b expected 0", oFrontSel); end
        n_cmp++; if (oSwapPending !== 1'b0) begin n_bad++; $display("FAIL blk_commit_pending: got %b expected 0", oSwapPending); end
        do_read(8'd10, d, v);
        n_cmp++; if (d !== 12'hA5A) begin n_bad++; $display("FAIL blk_addr10: got %h expected %h", d, 12'hA5A); end
        do_read(ADDR_W'(NPIX - 1), d, v);
        n_cmp++; if (d !== 12'hA5A) begin n_bad++; $display("FAIL blk_addr_last: got %h expected %h", d, 12'hA5A); end
    endtask

    // Front 0: clear bank 1 with 0x333, reset at clear cycle 100, restart.
    task automatic test_reset_mid_clear();
        int busy_cnt = 0;
        int done_cnt = 0;
        logic [PIX_W-1:0] d;
        logic v;
        iClearReq = 1'b1; iClearColor = 12'h333;
        tick();
        iClearReq = 1'b0;
        for (int k = 0; k < 100; k++) begin
            iRE = (k >= 98); iRAddr = 8'd10;
            tick();
        end
        n_cmp++; if (oClearBusy !== 1'b1) begin n_bad++; $display("FAIL rstclr_busy_before: got %b expected 1", oClearBusy); end
        n_cmp++; if (oRValid !== 1'b1) begin n_bad++; $display("FAIL rstclr_rvalid_before: got %b expected 1", oRValid); end
        iRst_n = 1'b0; iSwapReq = 1'b1;
        tick();
        n_cmp++; if (oRData !== 12'h000) begin n_bad++; $display("FAIL rstclr_rdata: got %h expected %h", oRData, 12'h000); end
        n_cmp++; if (oRValid !== 1'b0) begin n_bad++; $display("FAIL rstclr_rvalid: got %b expected 0", oRValid); end
        n_cmp++; if (oFrontSel !== 1'b0) begin n_bad++; $display("FAIL rstclr_front: got %b expected 0", oFrontSel); end
        n_cmp++; if (oSwapPending !== 1'b0) begin n_bad++; $display("FAIL rstclr_pending: got %b expected 0", oSwapPending); end
        n_cmp++; if (oClearBusy !== 1'b0) begin n_bad++; $display("FAIL rstclr_busy: got %b expected 0", oClearBusy); end
        n_cmp++; if (oClearDone !== 1'b0) begin n_bad++; $display("FAIL rstclr_done: got %b expected 0", oClearDone); end
        iRst_n = 1'b1; iRE = 1'b0; iSwapReq = 1'b0;
        tick();
        n_cmp++; if (oClearBusy !== 1'b0) begin n_bad++; $display("FAIL rstclr_abandoned: got %b expected 0", oClearBusy); end
        do_swap();
        do_read(8'd0, d, v);
        n_cmp++; if (d !== 12'h333) begin n_bad++; $display("FAIL rstclr_partial0: got %h expected %h", d, 12'h333); end
        do_read(ADDR_W'(NPIX - 1), d, v);
        n_cmp++; if (d !== 12'h0F0) begin n_bad++; $display("FAIL rstclr_untouched_last: got %h expected %h", d, 12'h0F0); end
        iClearReq = 1'b1; iClearColor = 12'h444;
        tick();
        iClearReq = 1'b0;
        for (int k = 0; k < NPIX + 5; k++) begin
            if (oClearBusy) busy_cnt++;
            if (oClearDone) done_cnt++;
            tick();
        end
        n_cmp++; if (busy_cnt !== NPIX) begin n_bad++; $display("FAIL rstclr_restart_busy: got %0d expected %0d", busy_cnt, NPIX); end
        n_cmp++; if (done_cnt !== 1) begin n_bad++; $display("FAIL rstclr_restart_done: got %0d expected 1", done_cnt); end
        do_swap();
        n_cmp++; if (oFrontSel !== 1'b0) begin n_bad++; $display("FAIL rstclr_front_after: got %b expected 0", oFrontSel); end
        do_read(8'd0, d, v);
        n_cmp++; if (d !== 12'h444) begin n_bad++; $display("FAIL rstclr_new0: got %h expected %h", d, 12'h444); end
        do_read(ADDR_W'(NPIX - 1), d, v);
        n_cmp++; if (d !== 12'h444) begin n_bad++; $display("FAIL rstclr_new_last: got %h expected %h", d, 12'h444); end
    endtask

    // Front 0 (all 0x444): simultaneous read+write, then streaming reads.
    task automatic test_back_to_back();
        for (int i = 0; i < 3; i++) begin
            iRE = 1'b1; iRAddr = ADDR_W'(i + 1);
            iWE = 1'b1; iWAddr = ADDR_W'(i + 1); iWData = PIX_W'(12'h101 + i);
            tick();
            n_cmp++; if (oRData !== 12'h444) begin n_bad++; $display("FAIL b2b_front i=%0d: got %h expected %h", i, oRData, 12'h444); end
            n_cmp++; if (oRValid !== 1'b1) begin n_bad++; $display("FAIL b2b_front_valid i=%0d: got %b expected 1", i, oRValid); end
        end
        iRE = 1'b0; iWE = 1'b0;
        do_swap();
        for (int i = 0; i < 3; i++) begin
            iRE = 1'b1; iRAddr = ADDR_W'(i + 1);
            tick();
            n_cmp++; if (oRData !== PIX_W'(12'h101 + i)) begin n_bad++; $display("FAIL b2b_back i=%0d: got %h expected %h", i, oRData, PIX_W'(12'h101 + i)); end
            n_cmp++; if (oRValid !== 1'b1) begin n_bad++; $display("FAIL b2b_back_valid i=%0d: got %b expected 1", i, oRValid); end
        end
        iRE = 1'b0;
        tick();
    endtask

    initial begin
        iRst_n = 1'b0; iWE = 1'b0; iWAddr = '0; iWData = '0;
        iRE = 1'b0; iRAddr = '0; iSwapReq = 1'b0; iFrameEnd = 1'b0;
        iClearReq = 1'b0; iClearColor = '0;
        test_reset();
        test_basic();
        test_range();
        test_swap_timing();
        test_clear();
        test_swap_during_clear();
        test_reset_mid_clear();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
